mm_port_arbiter: RTL and testbench

//  Shares the single Avalon read master and write master between NUM_REQ on-chip requesters
//  (block fetcher, nonce write-back, debug poller). Accepts one single-word transaction at a

---
 rtl/mm_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mm_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_port_arbiter.sv
// mm_port_arbiter
// Round-robin arbiter that lets NUM_REQ on-chip requesters share one Avalon
// read master and one Avalon write master. One single-word transaction is in
// flight at a time. The block sequences the master go/buffer handshakes and
// returns read data to the requester together with a one-cycle done pulse.
module mm_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDRESSWIDTH   = 28,
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATAWIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic [NUM_REQ-1:0]              req_done,
    output logic                            req_error,
    output logic [DATAWIDTH-1:0]            req_rdata,
    output logic                            busy,
    output logic                            write_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0]         write_control_write_base,
    output logic [ADDRESSWIDTH-1:0]         write_control_write_length,
    output logic                            write_control_go,
    input  logic                            write_control_done,
    output logic                            write_user_write_buffer,
    output logic [DATAWIDTH-1:0]            write_user_buffer_data,
    input  logic                            write_user_buffer_full,
    output logic                            read_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0]         read_control_read_base,
    output logic [ADDRESSWIDTH-1:0]         read_control_read_length,
    output logic                            read_control_go,
    input  logic                            read_control_done,
    output logic                            read_user_read_buffer,
    input  logic [DATAWIDTH-1:0]            read_user_buffer_output_data,
    input  logic                            read_user_data_available
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Pointer starts at the last requester so requester 0 wins first after reset.
    localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_GO,
        WR_WAIT,
        RD_GO,
        RD_WAIT,
        RD_ACK,
        RESP
    } state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           win;
    logic [IW-1:0]           cand_w;
    logic                    win_found;
    int                      cand;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0]    wdata_q;
    logic [DATAWIDTH-1:0]    rdata_q;
    logic [CW-1:0]           cnt;
    logic                    err_q;
    logic                    wait_ok;
    logic                    timeout_hit;

    // Round-robin search: first valid requester starting just after the pointer.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_w    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_w = IW'(cand);
            if (!win_found && req_valid[cand_w]) begin
                win       = cand_w;
                win_found = 1'b1;
            end
        end
    end

    // Completion and timeout qualifiers; a zero count marks the first wait
    // cycle, where a done still held from the previous transfer is ignored.
    always_comb begin
        wait_ok     = 1'b0;
        timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
        if (state == WR_WAIT)
            wait_ok = (cnt != '0) && write_control_done;
        else if (state == RD_WAIT)
            wait_ok = (cnt != '0) && read_control_done && read_user_data_available;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        state_nxt               = state;
        write_control_go        = 1'b0;
        write_user_write_buffer = 1'b0;
        read_control_go         = 1'b0;
        read_user_read_buffer   = 1'b0;
        req_grant               = '0;
        req_done                = '0;
        req_error               = 1'b0;
        if (state != IDLE) req_grant[idx] = 1'b1;
        case (state)
            IDLE: begin
                if (win_found) state_nxt = req_write[win] ? WR_GO : RD_GO;
            end
            WR_GO: begin
                if (!write_user_buffer_full) begin
                    write_control_go        = 1'b1;
                    write_user_write_buffer = 1'b1;
                    state_nxt               = WR_WAIT;
                end
            end
            RD_GO: begin
                read_control_go = 1'b1;
                state_nxt       = RD_WAIT;
            end
            WR_WAIT: begin
                if (wait_ok || timeout_hit) state_nxt = RESP;
            end
            RD_WAIT: begin
                if (wait_ok)          state_nxt = RD_ACK;
                else if (timeout_hit) state_nxt = RESP;
            end
            RD_ACK: begin
                read_user_read_buffer = 1'b1;
                state_nxt             = RESP;
            end
            RESP: begin
                req_done[idx] = 1'b1;
                req_error     = err_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning requester and its transaction on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            ptr     <= PTR_INIT;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && win_found) begin
            idx     <= win;
            ptr     <= win;
            addr_q  <= req_address[win*ADDRESSWIDTH +: ADDRESSWIDTH];
            wdata_q <= req_wdata[win*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Wait-state cycle counter and sticky timeout flag for the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (state == WR_GO || state == RD_GO) begin
            cnt <= '0;
        end else if (state == WR_WAIT || state == RD_WAIT) begin
            cnt <= cnt + CW'(1);
            if (timeout_hit && !wait_ok) err_q <= 1'b1;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end
    end

    // Capture read data while popping the read FIFO; held until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                rdata_q <= '0;
        else if (state == RD_ACK)  rdata_q <= read_user_buffer_output_data;
    end

    assign busy                         = (state != IDLE);
    assign req_rdata                    = rdata_q;
    assign write_control_fixed_location = 1'b1;
    assign read_control_fixed_location  = 1'b1;
    assign write_control_write_base     = addr_q;
    assign read_control_read_base       = addr_q;
    assign write_control_write_length   = ADDRESSWIDTH'(DATAWIDTH / 8);
    assign read_control_read_length     = ADDRESSWIDTH'(DATAWIDTH / 8);
    assign write_user_buffer_data       = wdata_q;

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Testbench for mm_port_arbiter: table of transactions with hand-computed
// grant order, latency and data, plus directed reset and reset-state checks.
module tb_mm_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int TO = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_address;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     req_done;
    logic              req_error;
    logic [DW-1:0]     req_rdata;
    logic              busy;
    logic              write_control_fixed_location;
    logic [AW-1:0]     write_control_write_base;
    logic [AW-1:0]     write_control_write_length;
    logic              write_control_go;
    logic              write_control_done;
    logic              write_user_write_buffer;
    logic [DW-1:0]     write_user_buffer_data;
    logic              write_user_buffer_full;
    logic              read_control_fixed_location;
    logic [AW-1:0]     read_control_read_base;
    logic [AW-1:0]     read_control_read_length;
    logic              read_control_go;
    logic              read_control_done;
    logic              read_user_read_buffer;
    logic [DW-1:0]     read_user_buffer_output_data;
    logic              read_user_data_available;

    int n_checks = 0;
    int n_errors = 0;

    mm_port_arbiter #(
        .NUM_REQ(NR), .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_grant(req_grant), .req_done(req_done), .req_error(req_error),
        .req_rdata(req_rdata), .busy(busy),
        .write_control_fixed_location(write_control_fixed_location),
        .write_control_write_base(write_control_write_base),
        .write_control_write_length(write_control_write_length),
        .write_control_go(write_control_go),
        .write_control_done(write_control_done),
        .write_user_write_buffer(write_user_write_buffer),
        .write_user_buffer_data(write_user_buffer_data),
        .write_user_buffer_full(write_user_buffer_full),
        .read_control_fixed_location(read_control_fixed_location),
        .read_control_read_base(read_control_read_base),
        .read_control_read_length(read_control_read_length),
        .read_control_go(read_control_go),
        .read_control_done(read_control_done),
        .read_user_read_buffer(read_user_read_buffer),
        .read_user_buffer_output_data(read_user_buffer_output_data),
        .read_user_data_available(read_user_data_available)
    );

    always #5 clk = ~clk;

    // One transaction record. mlat = cycles after go until the master raises
    // done (0 = never); stale = done also high before go and in the first
    // wait cycle. exp_lat counts cycles from the accept edge, inclusive.
    typedef struct {
        logic [1:0]         valid;
        logic [1:0]         wr;
        logic [1:0][AW-1:0] addr;
        logic [1:0][DW-1:0] wdata;
        logic [DW-1:0]      mem;
        int                 full;
        int                 mlat;
        bit                 stale;
        int                 exp_idx;
        bit                 exp_wr;
        int                 exp_lat;
        bit                 exp_err;
        logic [AW-1:0]      exp_base;
        logic [DW-1:0]      exp_wdata;
        logic [DW-1:0]      exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] wr,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] mem, input int full, input int mlat,
                                input bit stale, input int exp_idx, input bit exp_wr,
                                input int exp_lat, input bit exp_err,
                                input logic [AW-1:0] exp_base, input logic [DW-1:0] exp_wdata,
                                input logic [DW-1:0] exp_rdata);
        vec_t v;
        v.valid = valid; v.wr = wr; v.addr = {a1, a0}; v.wdata = {d1, d0};
        v.mem = mem; v.full = full; v.mlat = mlat; v.stale = stale;
        v.exp_idx = exp_idx; v.exp_wr = exp_wr; v.exp_lat = exp_lat; v.exp_err = exp_err;
        v.exp_base = exp_base; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Drive one transaction cycle by cycle (inputs at edge+1, sampling at edge+2)
    // acting as requesters and as both Avalon masters.
    task automatic run_txn(input vec_t v, input string tag);
        int         cyc, g, d, go_cyc, k, wgo, rgo, pops, bad_grant, bad_strobe;
        bit         seen_go, done_drv, busy0;
        logic [AW-1:0] base_go, len_go;
        logic [DW-1:0] wd_go;
        logic [1:0] done_v, onehot;
        logic       err_v;
        logic [DW-1:0] rdata_v;
        cyc = 0; g = -1; d = -1; go_cyc = 0; wgo = 0; rgo = 0; pops = 0;
        bad_grant = 0; bad_strobe = 0; seen_go = 0; busy0 = 1'b1;
        base_go = '0; len_go = '0; wd_go = '0; done_v = '0; err_v = 1'b0; rdata_v = '0;
        onehot = 2'(1 << v.exp_idx);
        while (cyc < 200 && d < 0) begin
            @(posedge clk); #1;
            req_valid   = v.valid;
            req_write   = v.wr;
            req_address = v.addr;
            req_wdata   = v.wdata;
            write_user_buffer_full = (v.full != 0 && cyc <= v.full);
            if (!seen_go) begin
                done_drv = v.stale;
            end else begin
                k = cyc - go_cyc;
                done_drv = (k == 1 && v.stale) || (v.mlat != 0 && k >= v.mlat);
            end
            write_control_done           = v.exp_wr ? done_drv : 1'b0;
            read_control_done            = v.exp_wr ? 1'b0 : done_drv;
            read_user_data_available     = v.exp_wr ? 1'b0 : done_drv;
            read_user_buffer_output_data = v.mem;
            #1;
            if (cyc == 0) busy0 = busy;
            if (g < 0 && req_grant != '0) g = cyc;
            if (g >= 0 && req_grant != onehot) bad_grant++;
            if (write_control_go != write_user_write_buffer) bad_strobe++;
            if (write_control_go) begin
                wgo++; seen_go = 1; go_cyc = cyc;
                base_go = write_control_write_base; len_go = write_control_write_length;
                wd_go = write_user_buffer_data;
            end
            if (read_control_go) begin
                rgo++; seen_go = 1; go_cyc = cyc;
                base_go = read_control_read_base; len_go = read_control_read_length;
            end
            if (read_user_read_buffer) pops++;
            if (req_done != '0) begin
                d = cyc; done_v = req_done; err_v = req_error; rdata_v = req_rdata;
            end else if (req_error) begin
                bad_strobe++;
            end
            cyc++;
        end
        chk({tag, " idle before accept"}, busy0, 0);
        if (d < 0) begin
            chk({tag, " done within bound"}, 0, 1);
        end else begin
            chk({tag, " latency"}, d - g + 1, v.exp_lat);
            chk({tag, " done vector"}, done_v, onehot);
            chk({tag, " error flag"}, err_v, v.exp_err);
            chk({tag, " rdata"}, rdata_v, v.exp_rdata);
            chk({tag, " grant cycles wrong"}, bad_grant, 0);
            chk({tag, " strobe mismatch"}, bad_strobe, 0);
            chk({tag, " write go count"}, wgo, v.exp_wr ? 1 : 0);
            chk({tag, " read go count"}, rgo, v.exp_wr ? 0 : 1);
            chk({tag, " pop count"}, pops, (!v.exp_wr && !v.exp_err) ? 1 : 0);
            chk({tag, " base"}, base_go, v.exp_base);
            chk({tag, " length"}, len_go, 4);
            if (v.exp_wr) chk({tag, " write data"}, wd_go, v.exp_wdata);
        end
    endtask

    // Hard stop if something stalls outside the bounded loops.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b0;
        req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0;
        write_control_done = 1'b0; write_user_buffer_full = 1'b0;
        read_control_done = 1'b0; read_user_data_available = 1'b0;
        read_user_buffer_output_data = '0;

        //            valid  wr     addr0         addr1         wdata0        wdata1        mem           full mlat stale idx wr  lat err base          wdata         rdata
        vecs[0] = mk(2'b01, 2'b00, 28'h8000000, 28'h0000044, 32'h0,        32'h0,        32'hAAAA0000, 0,   2,   0,    0,  0,  5,  0,  28'h8000000, 32'h0,        32'hAAAA0000);
        vecs[1] = mk(2'b10, 2'b10, 28'h0000010, 28'h8000090, 32'h11111111, 32'h12345678, 32'h0,        3,   2,   0,    1,  1,  7,  0,  28'h8000090, 32'h12345678, 32'hAAAA0000);
        vecs[2] = mk(2'b11, 2'b01, 28'h0000100, 28'h0000200, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0,        0,   2,   0,    0,  1,  4,  0,  28'h0000100, 32'hA0A0A0A0, 32'hAAAA0000);
        vecs[3] = mk(2'b11, 2'b01, 28'h0000104, 28'h0000204, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'h55AA1234, 0,   3,   0,    1,  0,  6,  0,  28'h0000204, 32'h0,        32'h55AA1234);
        vecs[4] = mk(2'b11, 2'b01, 28'h0000108, 28'h0000208, 32'hA2A2A2A2, 32'hB3B3B3B3, 32'h0,        0,   2,   0,    0,  1,  4,  0,  28'h0000108, 32'hA2A2A2A2, 32'h55AA1234);
        vecs[5] = mk(2'b11, 2'b01, 28'h000010C, 28'h000020C, 32'hA3A3A3A3, 32'hB4B4B4B4, 32'hCAFEF00D, 0,   2,   0,    1,  0,  5,  0,  28'h000020C, 32'h0,        32'hCAFEF00D);
        vecs[6] = mk(2'b01, 2'b01, 28'h0000300, 28'h0000400, 32'h0F0F0F0F, 32'h0,        32'h0,        0,   4,   1,    0,  1,  6,  0,  28'h0000300, 32'h0F0F0F0F, 32'hCAFEF00D);
        vecs[7] = mk(2'b10, 2'b10, 28'h0000500, 28'h0000600, 32'h0,        32'h600DCAFE, 32'h0,        0,   1,   1,    1,  1,  4,  0,  28'h0000600, 32'h600DCAFE, 32'hCAFEF00D);
        vecs[8] = mk(2'b01, 2'b00, 28'h0000700, 28'h0000800, 32'h0,        32'h0,        32'hDEADDEAD, 0,   0,   0,    0,  0,  34, 1,  28'h0000700, 32'h0,        32'hCAFEF00D);
        vecs[9] = mk(2'b11, 2'b00, 28'h0000900, 28'h0000A00, 32'h0,        32'h0,        32'h0BADBEEF, 0,   2,   0,    0,  0,  5,  0,  28'h0000900, 32'h0,        32'h0BADBEEF);

        // Reset state
        #1;
        chk("reset grant", req_grant, 0);
        chk("reset done", req_done, 0);
        chk("reset error", req_error, 0);
        chk("reset busy", busy, 0);
        chk("reset rdata", req_rdata, 0);
        chk("reset go strobes", {write_control_go, write_user_write_buffer, read_control_go, read_user_read_buffer}, 0);
        chk("reset bases", {write_control_write_base, read_control_read_base}, 0);
        chk("fixed location", {write_control_fixed_location, read_control_fixed_location}, 2'b11);
        chk("lengths", {write_control_write_length, read_control_read_length}, {28'd4, 28'd4});
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Reset asserted while a read from requester 0 sits in RD_WAIT.
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            req_valid = 2'b01; req_write = 2'b00;
            req_address = {28'h0000B00, 28'h0000C00};
            write_control_done = 1'b0; write_user_buffer_full = 1'b0;
            read_control_done = 1'b0; read_user_data_available = 1'b0;
            #1;
            if (i == 0) chk("rst seq idle after timeout", busy, 0);
            if (read_control_go) seen = 1;
        end
        chk("rst seq read go seen", seen, 1);
        @(posedge clk); #1;
        chk("rst seq busy in wait", busy, 1);
        chk("rst seq grant in wait", req_grant, 2'b01);
        chk("rst seq rdata before reset", req_rdata, 32'hCAFEF00D);
        #2 reset = 1'b0;
        #1;
        chk("async reset grant", req_grant, 0);
        chk("async reset busy", busy, 0);
        chk("async reset done/error", {req_done, req_error}, 0);
        chk("async reset rdata", req_rdata, 0);
        chk("async reset bases", {write_control_write_base, read_control_read_base}, 0);
        chk("async reset strobes", {write_control_go, write_user_write_buffer, read_control_go, read_user_read_buffer}, 0);
        req_valid = '0;
        @(posedge clk); #3;
        reset = 1'b1;

        // Both requesters valid after reset: requester 0 must win.
        run_txn(vecs[9], "v9");

        @(posedge clk); #1;
        req_valid = '0;
        #1;
        chk("final idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
